// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the 8-bit CPU.
// Sequences FETCH -> DECODE -> EXEC | MEM (-> WB) and raises the
// register-file, flag and data-memory strobes as Moore decodes of state+IR.
// Optional build macro: ILLEGAL_TRAP_EN (undefined encodings lock in TRAP
// with illegal=1). Without it undefined encodings behave as NOP.
module cpu_sequencer #(
   parameter logic [7:0] RESET_PC     = 8'h00,
   parameter int         MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] opcode1,
   input  logic [7:0] opcode2,
   output logic [7:0] rom_address,
   input  logic       carry_flag,
   input  logic       zero_flag,
   output logic [3:0] rf_raddr_a,
   output logic [3:0] rf_raddr_b,
   output logic [3:0] rf_waddr,
   output logic       rf_we,
   output logic [1:0] rf_wsel,
   output logic [7:0] imm,
   output logic       flags_we,
   output logic [7:0] mem_addr,
   output logic       mem_re,
   output logic       mem_we,
   input  logic       mem_ready,
   output logic       mem_abort,
   output logic       illegal
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
`ifdef ILLEGAL_TRAP_EN
   localparam logic [2:0] S_TRAP   = 3'd5;
`endif

   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_LD  = 4'h2;
   localparam logic [3:0] OP_ST  = 4'h3;
   localparam logic [3:0] OP_JMP = 4'h4;
   localparam logic [3:0] OP_ADD = 4'h8;

   // Last MEM cycle index before the access is abandoned.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

   logic [2:0]  state;
   logic [7:0]  pc;
   logic [15:0] ir;
   logic [7:0]  wait_cnt;
   logic        abort_q;

   logic [3:0]  op, ra, b1, b0;
   logic [7:0]  pc_plus2;
   logic        jmp_taken;

   assign op       = ir[15:12];
   assign ra       = ir[11:8];
   assign b1       = ir[7:4];
   assign b0       = ir[3:0];
   assign pc_plus2 = pc + 8'd2;

   // Jump condition resolution from the registered ALU flags.
   always_comb begin
      jmp_taken = 1'b0;
      case (ra)
         4'b1000: jmp_taken = 1'b1;
         4'b1001: jmp_taken = carry_flag;
         4'b1101: jmp_taken = ~carry_flag;
         4'b0010: jmp_taken = zero_flag;
         4'b0110: jmp_taken = ~zero_flag;
         default: jmp_taken = 1'b0;
      endcase
   end

`ifdef ILLEGAL_TRAP_EN
   logic op_legal;
   // Recognised opcodes, with JMP only legal for its five condition codes.
   always_comb begin
      op_legal = 1'b0;
      case (op)
         OP_NOP, OP_LDI, OP_LD, OP_ST, OP_ADD: op_legal = 1'b1;
         OP_JMP: op_legal = (ra == 4'b1000) || (ra == 4'b1001) || (ra == 4'b1101) ||
                            (ra == 4'b0010) || (ra == 4'b0110);
         default: op_legal = 1'b0;
      endcase
   end
`endif

   // Sequencer state, PC, instruction register and MEM wait counter.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_FETCH;
         pc       <= RESET_PC;
         ir       <= 16'h0000;
         wait_cnt <= 8'd0;
         abort_q  <= 1'b0;
      end else begin
         abort_q <= 1'b0;
         case (state)
            S_FETCH: begin
               ir    <= {opcode1, opcode2};
               state <= S_DECODE;
            end
            S_DECODE: begin
               wait_cnt <= 8'd0;
               if (op == OP_LD || op == OP_ST) state <= S_MEM;
`ifdef ILLEGAL_TRAP_EN
               else if (!op_legal)             state <= S_TRAP;
`endif
               else                            state <= S_EXEC;
            end
            S_EXEC: begin
               pc    <= (op == OP_JMP && jmp_taken) ? ir[7:0] : pc_plus2;
               state <= S_FETCH;
            end
            S_MEM: begin
               if (mem_ready) begin
                  if (op == OP_LD) state <= S_WB;
                  else begin
                     pc    <= pc_plus2;
                     state <= S_FETCH;
                  end
               end else if (wait_cnt == WAIT_LAST) begin
                  // Give up on the access: skip the instruction, no RF write.
                  abort_q <= 1'b1;
                  pc      <= pc_plus2;
                  state   <= S_FETCH;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            S_WB: begin
               pc    <= pc_plus2;
               state <= S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: state <= S_TRAP;
`endif
            default: state <= S_FETCH;
         endcase
      end
   end

   assign rom_address = pc;
   assign imm         = ir[7:0];
   assign mem_addr    = ir[7:0];
   assign rf_raddr_a  = ra;
   assign rf_raddr_b  = b1;
   assign rf_waddr    = (op == OP_ADD) ? b0 : ra;
   assign rf_wsel     = (op == OP_ADD) ? 2'd1 : (op == OP_LD) ? 2'd2 : 2'd0;
   assign rf_we       = (state == S_EXEC && (op == OP_LDI || op == OP_ADD)) || (state == S_WB);
   assign flags_we    = (state == S_EXEC) && (op == OP_ADD);
   assign mem_re      = (state == S_MEM) && (op == OP_LD);
   assign mem_we      = (state == S_MEM) && (op == OP_ST);
   assign mem_abort   = abort_q;
`ifdef ILLEGAL_TRAP_EN
   assign illegal     = (state == S_TRAP);
`else
   assign illegal     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed vector table, hand sequences (wrap, reset in
// MEM, trap) and a random program checked cycle by cycle against an
// instruction-level model. Honours ILLEGAL_TRAP_EN like the design.
module tb_cpu_sequencer;

   localparam int MWM = 15;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] opcode1, opcode2, rom_address;
   logic       carry_flag = 1'b0, zero_flag = 1'b0;
   logic [3:0] rf_raddr_a, rf_raddr_b, rf_waddr;
   logic       rf_we, flags_we, mem_re, mem_we, mem_abort, illegal;
   logic [1:0] rf_wsel;
   logic [7:0] imm, mem_addr;
   logic       mem_ready = 1'b0;

   logic [7:0] rom [0:255];

   int errs = 0;
   int checks = 0;

   // model state
   logic [7:0] mpc;
   bit         ab_pend;
   int         mdelay;

   always #5 clk = ~clk;

   assign opcode1 = rom[rom_address];
   assign opcode2 = (rom_address == 8'hFF) ? 8'h00 : rom[rom_address + 8'd1];

   cpu_sequencer #(.RESET_PC(8'h00), .MEM_WAIT_MAX(MWM)) dut (
      .clk(clk), .reset(reset), .opcode1(opcode1), .opcode2(opcode2),
      .rom_address(rom_address), .carry_flag(carry_flag), .zero_flag(zero_flag),
      .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr),
      .rf_we(rf_we), .rf_wsel(rf_wsel), .imm(imm), .flags_we(flags_we),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_ready(mem_ready),
      .mem_abort(mem_abort), .illegal(illegal)
   );

   typedef struct {
      logic [7:0] pc, op1, op2;
      bit         c, z;
      int         dly;
      int         cyc;
      logic [7:0] npc;
      int         nwe, nflg, nmem;
      bit         ab;
      logic [3:0] wa;
      logic [1:0] ws;
      logic [7:0] im, ma;
      bit         chk_ra;
      logic [3:0] ra, rb;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // One cycle of expected behaviour; strobe order {we,flg,re,wr,abort,illegal}.
   task automatic step(input logic [7:0] e_pc, input logic [5:0] e_st,
                       input logic [3:0] e_wa, input logic [1:0] e_ws, input logic [7:0] e_im,
                       input logic [7:0] e_ma, input logic [3:0] e_ra, input logic [3:0] e_rb,
                       input logic rdy);
      chk("rom_address", rom_address, e_pc);
      chk("strobes", {rf_we, flags_we, mem_re, mem_we, mem_abort, illegal}, e_st);
      if (e_st[5]) begin
         chk("rf_waddr", rf_waddr, e_wa);
         chk("rf_wsel", rf_wsel, e_ws);
         if (e_ws == 2'd0) chk("imm", imm, e_im);
      end
      if (e_st[4]) begin
         chk("rf_raddr_a", rf_raddr_a, e_ra);
         chk("rf_raddr_b", rf_raddr_b, e_rb);
      end
      if (e_st[3] | e_st[2]) chk("mem_addr", mem_addr, e_ma);
      if (e_st[2]) chk("st_raddr_a", rf_raddr_a, e_ra);
      mem_ready = rdy;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Instruction-level model: expected cycle trace of the instruction at mpc.
   task automatic run_instr();
      logic [15:0] ir;
      logic [3:0]  op, ra;
      logic [7:0]  nxt;
      bit          taken, rd;
      ir  = {rom[mpc], (mpc == 8'hFF) ? 8'h00 : rom[mpc + 8'd1]};
      op  = ir[15:12];
      ra  = ir[11:8];
      nxt = mpc + 8'd2;
      step(mpc, {4'b0000, ab_pend, 1'b0}, 0, 0, 0, 0, 0, 0, 1'($urandom));
      ab_pend = 1'b0;
      step(mpc, 6'b0, 0, 0, 0, 0, 0, 0, 1'($urandom));
      case (op)
         4'h1: step(mpc, 6'b100000, ra, 2'd0, ir[7:0], 0, 0, 0, 1'($urandom));
         4'h8: step(mpc, 6'b110000, ir[3:0], 2'd1, 0, 0, ra, ir[7:4], 1'($urandom));
         4'h4: begin
            taken = (ra == 4'h8) || (ra == 4'h9 && carry_flag) || (ra == 4'hD && !carry_flag) ||
                    (ra == 4'h2 && zero_flag) || (ra == 4'h6 && !zero_flag);
            step(mpc, 6'b0, 0, 0, 0, 0, 0, 0, 1'($urandom));
            if (taken) nxt = ir[7:0];
         end
         4'h2, 4'h3: begin
            rd = 1'b0;
            for (int i = 0; i < MWM && !rd; i++) begin
               rd = (i == mdelay);
               step(mpc, (op == 4'h2) ? 6'b001000 : 6'b000100, 0, 0, 0, ir[7:0], ra, 0, rd);
            end
            if (!rd) ab_pend = 1'b1;
            else if (op == 4'h2) step(mpc, 6'b100000, ra, 2'd2, 0, 0, 0, 0, 1'($urandom));
         end
         default: step(mpc, 6'b0, 0, 0, 0, 0, 0, 0, 1'($urandom));
      endcase
      mpc = nxt;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_rom_address", rom_address, 8'h00);
      chk("rst_strobes", {rf_we, flags_we, mem_re, mem_we, mem_abort, illegal}, 6'b0);
      chk("rst_addrs", {rf_raddr_a, rf_raddr_b, rf_waddr, rf_wsel}, 14'h0);
      chk("rst_imm_maddr", {imm, mem_addr}, 16'h0000);
      reset   = 1'b1;
      mpc     = 8'h00;
      ab_pend = 1'b0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t t;
      int cyc, nwe, nflg, nmem, midx, nops;
      logic [3:0] cwa, cra, crb;
      logic [1:0] cws;
      logic [7:0] cim, cma, last;
      logic [3:0] rop, rra;
      logic [7:0] tgt;
      int r, v;

      for (int i = 0; i < 256; i++) rom[i] = 8'h00;

      //      pc    op1   op2   c z dly cyc npc   we f mem ab wa   ws    im    ma    cra ra   rb
      tbl.push_back('{8'h00,8'h00,8'h00,0,0,0, 3,8'h02, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h02,8'h10,8'hFF,0,0,0, 3,8'h04, 1,0,0, 0, 4'h0,2'd0,8'hFF,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h04,8'h80,8'h13,0,0,0, 3,8'h06, 1,1,0, 0, 4'h3,2'd1,8'h00,8'h00, 1,4'h0,4'h1});
      tbl.push_back('{8'h06,8'h33,8'h82,0,0,2, 5,8'h08, 0,0,3, 0, 4'h0,2'd0,8'h00,8'h82, 1,4'h3,4'h0});
      tbl.push_back('{8'h08,8'h25,8'h40,0,0,0, 4,8'h0A, 1,0,1, 0, 4'h5,2'd2,8'h00,8'h40, 0,4'h0,4'h0});
      tbl.push_back('{8'h0A,8'h49,8'h20,1,0,0, 3,8'h20, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h20,8'h49,8'h30,0,0,0, 3,8'h22, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h22,8'h4D,8'h30,0,0,0, 3,8'h30, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h30,8'h42,8'h40,0,1,0, 3,8'h40, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h40,8'h46,8'h50,0,1,0, 3,8'h42, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h42,8'h48,8'h50,0,0,0, 3,8'h50, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h50,8'h21,8'h60,0,0,20,17,8'h52, 0,0,15,1, 4'h0,2'd0,8'h00,8'h60, 0,4'h0,4'h0});
      tbl.push_back('{8'h52,8'h8F,8'hEA,1,1,0, 3,8'h54, 1,1,0, 0, 4'hA,2'd1,8'h00,8'h00, 1,4'hF,4'hE});
      tbl.push_back('{8'h54,8'h3E,8'hC4,0,0,0, 3,8'h56, 0,0,1, 0, 4'h0,2'd0,8'h00,8'hC4, 1,4'hE,4'h0});
      tbl.push_back('{8'h56,8'h4D,8'h70,1,0,0, 3,8'h58, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h58,8'h46,8'h70,0,0,0, 3,8'h70, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
`ifndef ILLEGAL_TRAP_EN
      tbl.push_back('{8'h70,8'h70,8'h00,0,0,0, 3,8'h72, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h72,8'h9C,8'h00,0,0,0, 3,8'h74, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h74,8'h4F,8'h00,1,1,0, 3,8'h76, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
      tbl.push_back('{8'h76,8'hF0,8'h11,0,0,0, 3,8'h78, 0,0,0, 0, 4'h0,2'd0,8'h00,8'h00, 0,4'h0,4'h0});
`endif
      foreach (tbl[k]) begin
         rom[tbl[k].pc]        = tbl[k].op1;
         rom[tbl[k].pc + 8'd1] = tbl[k].op2;
      end

      @(negedge clk);
      do_reset();

      // ---- vector table ----
      for (int k = 0; k < tbl.size(); k++) begin
         t = tbl[k];
         carry_flag = t.c;
         zero_flag  = t.z;
         cyc = 0; nwe = 0; nflg = 0; nmem = 0; midx = 0;
         cwa = 0; cws = 0; cim = 0; cma = 0; cra = 0; crb = 0;
         chk("tbl_start_pc", rom_address, t.pc);
         do begin
            if (rf_we) begin nwe++; cwa = rf_waddr; cws = rf_wsel; cim = imm; end
            if (flags_we) begin nflg++; cra = rf_raddr_a; crb = rf_raddr_b; end
            if (mem_re | mem_we) begin
               nmem++;
               cma = mem_addr;
               if (mem_we) cra = rf_raddr_a;
               mem_ready = (midx == t.dly);
               midx++;
            end else begin
               mem_ready = 1'b1;   // outside MEM it must be ignored
            end
            cyc++;
            @(posedge clk);
            @(negedge clk);
         end while (rom_address == t.pc && cyc < 40);
         chk("tbl_cycles", 16'(cyc), 16'(t.cyc));
         chk("tbl_next_pc", rom_address, t.npc);
         chk("tbl_rf_we_cnt", 16'(nwe), 16'(t.nwe));
         chk("tbl_flags_we_cnt", 16'(nflg), 16'(t.nflg));
         chk("tbl_mem_cnt", 16'(nmem), 16'(t.nmem));
         chk("tbl_mem_abort", mem_abort, t.ab);
         if (t.nwe > 0) begin
            chk("tbl_waddr", cwa, t.wa);
            chk("tbl_wsel", cws, t.ws);
            if (t.ws == 2'd0) chk("tbl_imm", cim, t.im);
         end
         if (t.nflg > 0) chk("tbl_raddr_b", crb, t.rb);
         if (t.chk_ra) chk("tbl_raddr_a", cra, t.ra);
         if (t.nmem > 0) chk("tbl_mem_addr", cma, t.ma);
      end

      // ---- hand sequences: PC wrap, conditional jump back, reset inside MEM ----
      last = rom_address;
      rom[last] = 8'h48; rom[last + 8'd1] = 8'hFE;
      rom[8'hFE] = 8'h00; rom[8'hFF] = 8'h00;
      rom[8'h00] = 8'h49; rom[8'h01] = 8'h02;
      rom[8'h02] = 8'h21; rom[8'h03] = 8'h10;
      mpc = last; ab_pend = 1'b0; mdelay = 0;
      carry_flag = 1'b1; zero_flag = 1'b0;
      run_instr();
      chk("jmp_to_fe", rom_address, 8'hFE);
      run_instr();
      chk("pc_wrap", rom_address, 8'h00);
      run_instr();
      chk("jmp_c1_back", rom_address, 8'h02);
      repeat (3) begin
         mem_ready = 1'b0;
         @(posedge clk);
         @(negedge clk);
      end
      chk("mid_mem_re", {mem_re, mem_addr}, 9'h110);
      do_reset();

`ifdef ILLEGAL_TRAP_EN
      // ---- trap: locks with illegal=1 and frozen pc until reset ----
      rom[8'h00] = 8'h70; rom[8'h01] = 8'h00;
      step(8'h00, 6'b0, 0, 0, 0, 0, 0, 0, 1'b1);
      step(8'h00, 6'b0, 0, 0, 0, 0, 0, 0, 1'b1);
      repeat (5) step(8'h00, 6'b000001, 0, 0, 0, 0, 0, 0, 1'b1);
      do_reset();
`endif

      // ---- random program against the model ----
      for (int a = 0; a < 256; a += 2) begin
`ifdef ILLEGAL_TRAP_EN
         r = $urandom_range(0, 5);
`else
         r = $urandom_range(0, 6);
`endif
         case (r)
            0: rop = 4'h0;
            1: rop = 4'h1;
            2: rop = 4'h2;
            3: rop = 4'h3;
            4: rop = 4'h4;
            5: rop = 4'h8;
            default: begin
               v = $urandom_range(5, 15);
               if (v == 8) v = 9;
               rop = 4'(v);
            end
         endcase
         rra = 4'($urandom);
         tgt = 8'($urandom);
         if (rop == 4'h4) begin
            case ($urandom_range(0, 5))
               0: rra = 4'h8;
               1: rra = 4'h9;
               2: rra = 4'hD;
               3: rra = 4'h2;
               4: rra = 4'h6;
               default: begin
`ifdef ILLEGAL_TRAP_EN
                  rra = 4'h8;
`endif
               end
            endcase
`ifdef ILLEGAL_TRAP_EN
            tgt = tgt & 8'hFE;
`endif
         end
         rom[a]     = {rop, rra};
         rom[a + 1] = tgt;
      end
      nops = 0;
      for (int n = 0; n < 300; n++) begin
         carry_flag = 1'($urandom);
         zero_flag  = 1'($urandom);
         r = $urandom_range(0, 9);
         if (r < 6) mdelay = r % 3;
         else if (r == 6) mdelay = 13;
         else if (r == 7) mdelay = 14;
         else if (r == 8) mdelay = 15;
         else mdelay = 20;
         run_instr();
         nops++;
      end
      chk("random_instr_count", 16'(nops), 16'd300);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
